fmul_seq: RTL
=============

# fmul_seq

Sequential, parametrised IEEE-754-style floating-point multiplier with valid/ready handshakes on input and output. Computes the mantissa product with a shift-add datapath, one multiplier bit per cycle, so the area cost is one adder instead of a full array. The block also adds round-to-nearest-even, IEEE special-value handling and saturating overflow. It is the multi-cycle successor to the combinational single-precision multiplier and feeds the same FPU result/flag bus.

## Interface
- `EXP`, default 8: exponent field width; must be at least 3.
- `FRAC`, default 23: fraction field width; must be at least 2.
- `WIDTH`, default EXP+FRAC+1: word width; derived, not overridden.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operands valid.
- `in_ready` out 1: block can accept operands.
- `a`, `b` in WIDTH: operands in the format {sign, exponent, fraction}.
- `round_mode` in 1: 1 selects round-to-nearest-even, 0 selects truncate (toward zero). Sampled at accept.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `r` out WIDTH: result.
- `flags` out 5: [4] invalid, [3] divzero (always 0), [2] overflow, [1] underflow, [0] inexact.

## Operation
- FSM states: IDLE, MUL, NORM, ROUND, DONE.
- `in_ready` = (state==IDLE). `out_valid` = (state==DONE).
- **IDLE:** on `in_valid` the block registers a, b and round_mode and classifies both operands.
- **Special operands** go straight to DONE:
  - An exponent of 0 is treated as zero, whatever the fraction (subnormal flush-to-zero, no flag).
  - NaN operand, or inf×zero, gives the canonical qNaN {0, all-ones exponent, fraction MSB=1, rest 0}.
  - invalid is set for inf×zero or any signalling NaN (fraction MSB=0).
  - inf×finite-nonzero gives signed inf, flags 0.
  - zero×finite gives signed zero, flags 0.
- **Normal operands** enter MUL:
  - Mantissas are {1, frac}, FRAC+1 bits each.
  - Accumulator is 2·FRAC+2 bits and cleared on accept.
  - Each MUL cycle examines one multiplier bit, LSB first, and adds the shifted multiplicand when that bit is 1.
  - A counter runs FRAC+1 iterations.
- Exponent arithmetic is signed, EXP+2 bits: e = ea + eb − bias, where bias = 2^(EXP−1)−1.
- Result sign = sign_a ^ sign_b, for every result including zero and inf. The qNaN sign is always 0.
- **NORM:**
  - If product MSB=1: e+=1, and keep the FRAC bits below the MSB. Otherwise keep the FRAC bits below MSB−1.
  - Guard = next bit down, round = the bit after, sticky = OR of all remaining bits.
- **ROUND:**
  - Nearest mode increments when G & (R | S | LSB). Truncate mode never increments.
  - If the increment carries out of the mantissa, shift right 1 and e+=1.
  - inexact = G | R | S.
- **Final classification:**
  - e ≥ 2^EXP−1 is overflow. Nearest mode gives signed inf; truncate mode gives signed max finite (exponent 2^EXP−2, fraction all ones). Flags overflow|inexact.
  - e ≤ 0 is underflow. Result is signed zero, flags underflow|inexact.
- **DONE:** r and flags are held stable until `out_valid & out_ready`, then the FSM returns to IDLE.

## Timing
- Reset (asynchronous, any state) forces:
  - state=IDLE, `in_ready`=1, `out_valid`=0, `r`=0, `flags`=0.
  - An in-flight operation is discarded and produces no output.
- Accepting on rising edge E0 gives the following latency:
  - Normal path: MUL covers edges E1…E(FRAC+1), NORM is at E(FRAC+2), ROUND is at E(FRAC+3). `out_valid` is high after E(FRAC+3), which is 26 cycles for the default parameters.
  - Special path: `out_valid` is high after E1.
- `out_ready` may be high before `out_valid`. The handshake completes on the first edge where both are high.
- Backpressure has no limit. r and flags must not change while `out_valid`=1 and `out_ready`=0.
- `in_ready` is low from the accept edge until the edge after the output handshake, so no new operation is accepted in the DONE→IDLE cycle. Minimum initiation interval is FRAC+5 cycles.
- a, b and round_mode are don't-care after the accept edge.

## Test plan
- 0x3FC00000 × 0x40000000, nearest mode → r=0x40400000, flags=0, `out_valid` exactly 26 cycles after the accept edge.
- 0x3F800800 × 0x3F800800 (exact tie, LSB 0), nearest mode → r=0x3F801000, flags=5'b00001. 0x3F800001 × 0x3F800001 → r=0x3F800002, flags=5'b00001, in both modes.
- 0x7F000000 × 0x7F000000 → nearest: r=0x7F800000, flags=5'b00101. Truncate: r=0x7F7FFFFF, flags=5'b00101. 0x80800000 × 0x00800000 → r=0x80000000, flags=5'b00011.
- 0x7F800000 × 0x00000000 → r=0x7FC00000, flags=5'b10000, `out_valid` 1 cycle after accept. 0xFF800000 × 0x40000000 → r=0xFF800000, flags=0.
- Hold `out_ready`=0 for 10 cycles after `out_valid` → r and flags stable, `in_ready`=0, and an `in_valid` pulse is ignored. Raise `out_ready` → `in_ready`=1 the next cycle and a back-to-back operation completes correctly.
- Assert `rst_n`=0 mid-MUL (cycle 10) → `out_valid`=0 and `in_ready`=1 immediately with no clock edge. After release, a fresh 1.5×2.0 yields 0x40400000.

Source files
------------

// File: rtl/fmul_seq_if.sv
// fmul_seq_if: operand/result bundle for the sequential floating-point
// multiplier.
//
// Handshake rules (both channels):
//   A transfer happens on a rising clock edge where valid and ready are both
//   high. The producer holds valid and its payload steady until that edge.
//   Ready may be raised before valid. Ready never depends on the valid of the
//   same channel within the cycle.
//   Input channel : in_valid / in_ready, payload a, b, round_mode.
//   Output channel: out_valid / out_ready, payload r, flags.
//
// Signals:
//   in_valid   operands valid (producer -> multiplier)
//   in_ready   multiplier can accept operands
//   a, b       operands {sign, exponent, fraction}
//   round_mode 1 = round-to-nearest-even, 0 = truncate
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   r          result word
//   flags      {invalid, divzero, overflow, underflow, inexact}
interface fmul_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             round_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] r;
    logic [4:0]       flags;

    // Operand producer / result consumer side.
    modport master (
        output in_valid, a, b, round_mode, out_ready,
        input  in_ready, out_valid, r, flags
    );

    // Multiplier side.
    modport slave (
        input  in_valid, a, b, round_mode, out_ready,
        output in_ready, out_valid, r, flags
    );
endinterface

// File: rtl/fmul_seq.sv
// fmul_seq: sequential IEEE-754-style floating-point multiplier.
// The mantissa product is built with a shift-add loop, one multiplier bit per
// cycle, followed by a normalise step and a round step. Special operands
// (zero/subnormal, inf, NaN) bypass the loop.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   bus      fmul_seq_if slave modport (operand and result handshakes)
//   o_state  current FSM state (IDLE=0, MUL=1, NORM=2, ROUND=3, DONE=4)
module fmul_seq #(
    parameter int EXP  = 8,
    parameter int FRAC = 23
) (
    input  logic        clk,
    input  logic        rst_n,
    fmul_seq_if.slave   bus,
    output logic [2:0]  o_state
);
    localparam int WIDTH = EXP + FRAC + 1;
    localparam int P     = 2 * FRAC + 2;          // product width
    localparam int CNT_W = $clog2(FRAC + 1);

    localparam logic signed [EXP+1:0] BIAS = (EXP+2)'((1 << (EXP - 1)) - 1);
    localparam logic signed [EXP+1:0] EMAX = (EXP+2)'((1 << EXP) - 1);
    localparam logic signed [EXP+1:0] ONE  = (EXP+2)'(1);
    localparam logic signed [EXP+1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] QNAN =
        {1'b0, {EXP{1'b1}}, 1'b1, {(FRAC-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL   = 3'd1,
        S_NORM  = 3'd2,
        S_ROUND = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t r_state, w_next;

    logic [P-1:0]            r_acc;
    logic [P-1:0]            r_mcand;
    logic [FRAC:0]           r_mplier;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [EXP+1:0]   r_exp;
    logic                    r_sign;
    logic                    r_rmode;
    logic                    r_special;
    logic [FRAC-1:0]         r_frac;
    logic                    r_g;
    logic                    r_rb;
    logic                    r_s;
    logic [WIDTH-1:0]        r_r;
    logic [4:0]              r_flags;

    // ---------------- operand classification at accept ----------------
    logic [EXP-1:0]  w_ea, w_eb;
    logic [FRAC-1:0] w_fa, w_fb;
    logic            w_sign;
    logic            w_za, w_zb, w_nan_a, w_nan_b, w_snan_a, w_snan_b;
    logic            w_inf_a, w_inf_b;
    logic            w_special;
    logic [WIDTH-1:0] w_spec_r;
    logic [4:0]      w_spec_flags;
    logic signed [EXP+1:0] w_exp_sum;

    assign w_ea   = bus.a[WIDTH-2 -: EXP];
    assign w_eb   = bus.b[WIDTH-2 -: EXP];
    assign w_fa   = bus.a[FRAC-1:0];
    assign w_fb   = bus.b[FRAC-1:0];
    assign w_sign = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];

    // Exponent 0 counts as zero regardless of fraction (flush-to-zero).
    assign w_za     = (w_ea == '0);
    assign w_zb     = (w_eb == '0);
    assign w_nan_a  = (w_ea == '1) && (w_fa != '0);
    assign w_nan_b  = (w_eb == '1) && (w_fb != '0);
    assign w_snan_a = w_nan_a && !w_fa[FRAC-1];
    assign w_snan_b = w_nan_b && !w_fb[FRAC-1];
    assign w_inf_a  = (w_ea == '1) && (w_fa == '0);
    assign w_inf_b  = (w_eb == '1) && (w_fb == '0);

    assign w_exp_sum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS;

    always_comb begin
        w_special    = 1'b0;
        w_spec_r     = '0;
        w_spec_flags = '0;
        if (w_nan_a || w_nan_b || (w_inf_a && w_zb) || (w_inf_b && w_za)) begin
            w_special    = 1'b1;
            w_spec_r     = QNAN;
            w_spec_flags = {(w_snan_a || w_snan_b || (w_inf_a && w_zb) ||
                             (w_inf_b && w_za)), 4'b0000};
        end else if (w_inf_a || w_inf_b) begin
            w_special = 1'b1;
            w_spec_r  = {w_sign, {EXP{1'b1}}, {FRAC{1'b0}}};
        end else if (w_za || w_zb) begin
            w_special = 1'b1;
            w_spec_r  = {w_sign, {(WIDTH-1){1'b0}}};
        end
    end

    // ---------------- normalise ----------------
    // Product is in [1,4): align so the leading one sits just above bit P-2,
    // then the fraction/guard/round/sticky positions are fixed.
    logic [P-2:0] w_norm;
    assign w_norm = r_acc[P-1] ? r_acc[P-2:0] : {r_acc[P-3:0], 1'b0};

    // ---------------- round and final classification ----------------
    logic                  w_inc;
    logic [FRAC+1:0]       w_sum;
    logic signed [EXP+1:0] w_exp_r;
    logic [FRAC-1:0]       w_frac_r;
    logic                  w_inexact;
    logic [WIDTH-1:0]      w_round_r;
    logic [4:0]            w_round_flags;

    assign w_inc     = r_rmode && r_g && (r_rb || r_s || r_frac[0]);
    assign w_sum     = {1'b0, 1'b1, r_frac} + (FRAC+2)'(w_inc);
    // A carry out means the mantissa became 10.000..., i.e. 1.0 one binade up.
    assign w_exp_r   = w_sum[FRAC+1] ? r_exp + ONE : r_exp;
    assign w_frac_r  = w_sum[FRAC+1] ? w_sum[FRAC:1] : w_sum[FRAC-1:0];
    assign w_inexact = r_g || r_rb || r_s;

    always_comb begin
        w_round_r     = {r_sign, w_exp_r[EXP-1:0], w_frac_r};
        w_round_flags = {4'b0000, w_inexact};
        if (w_exp_r >= EMAX) begin
            w_round_flags = 5'b00101;
            if (r_rmode)
                w_round_r = {r_sign, {EXP{1'b1}}, {FRAC{1'b0}}};
            else
                w_round_r = {r_sign, {(EXP-1){1'b1}}, 1'b0, {FRAC{1'b1}}};
        end else if (w_exp_r <= ZERO) begin
            w_round_flags = 5'b00011;
            w_round_r     = {r_sign, {(WIDTH-1){1'b0}}};
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Special operands still spend one cycle in MUL (the accept cycle only
    // registers them) and leave on its first edge without iterating.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid) w_next = S_MUL;
            S_MUL: begin
                if (r_special)                       w_next = S_DONE;
                else if (r_cnt == CNT_W'(FRAC))      w_next = S_NORM;
            end
            S_NORM:  w_next = S_ROUND;
            S_ROUND: w_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.r         = r_r;
    assign bus.flags     = r_flags;
    assign o_state       = r_state;

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_exp     <= '0;
            r_sign    <= 1'b0;
            r_rmode   <= 1'b0;
            r_special <= 1'b0;
            r_frac    <= '0;
            r_g       <= 1'b0;
            r_rb      <= 1'b0;
            r_s       <= 1'b0;
            r_r       <= '0;
            r_flags   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_rmode   <= bus.round_mode;
                        r_sign    <= w_sign;
                        r_special <= w_special;
                        r_mcand   <= {{(P-FRAC-1){1'b0}}, 1'b1, w_fa};
                        r_mplier  <= {1'b1, w_fb};
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        r_exp     <= w_exp_sum;
                        if (w_special) begin
                            r_r     <= w_spec_r;
                            r_flags <= w_spec_flags;
                        end
                    end
                end
                S_MUL: begin
                    if (!r_special) begin
                        if (r_mplier[0])
                            r_acc <= r_acc + r_mcand;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + 1'b1;
                    end
                end
                S_NORM: begin
                    r_frac <= w_norm[P-2 -: FRAC];
                    r_g    <= w_norm[P-2-FRAC];
                    r_rb   <= w_norm[P-3-FRAC];
                    r_s    <= |w_norm[P-4-FRAC:0];
                    if (r_acc[P-1])
                        r_exp <= r_exp + ONE;
                end
                S_ROUND: begin
                    r_r     <= w_round_r;
                    r_flags <= w_round_flags;
                end
                default: ;
            endcase
        end
    end
endmodule
